// File: rtl/conv3x3_stream_filter_if.sv
// Pixel stream bundle for conv3x3_stream_filter: input beat, frame controls and filtered output.
interface conv3x3_stream_filter_if #(
    parameter int unsigned DW = 12
);
    logic [DW-1:0] iDATA;
    logic          iDVAL;
    logic          iSOF;
    logic [2:0]    iMODE;
    logic [DW-1:0] iTHRESH;
    logic          iTHRESH_EN;
    logic [DW-1:0] oDATA;
    logic          oDVAL;

    modport master (
        output iDATA, iDVAL, iSOF, iMODE, iTHRESH, iTHRESH_EN,
        input  oDATA, oDVAL
    );

    modport slave (
        input  iDATA, iDVAL, iSOF, iMODE, iTHRESH, iTHRESH_EN,
        output oDATA, oDVAL
    );
endinterface

// File: rtl/conv3x3_stream_filter.sv
// 3x3 streaming filter: passthrough, Sobel Gx/Gy, |Gx|+|Gy|, 1-2-1 blur, threshold, border mask.
// Input register, window stage, gradient stage, select stage: oDVAL follows its beat by 3 edges.
module conv3x3_stream_filter #(
    parameter int unsigned DW        = 12,
    parameter int unsigned IMG_WIDTH = 640,
    parameter int unsigned CW        = 11
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    conv3x3_stream_filter_if.slave bus
);
    localparam int unsigned   SW   = DW + 4;
    localparam logic [DW-1:0] MAXV = '1;

    function automatic logic [SW-1:0] zx(input logic [DW-1:0] v);
        zx = {4'b0000, v};
    endfunction

    function automatic logic [SW:0] zx5(input logic [DW-1:0] v);
        zx5 = {5'b00000, v};
    endfunction

    // Input stage and frame-latched controls
    logic [CW-1:0] r_col, w_col;
    logic [1:0]    r_row, w_row;
    logic [2:0]    r_mode, w_mode;
    logic          r_ten, w_ten;
    logic          r_in_vld, r_in_mask, r_in_ten;
    logic [DW-1:0] r_in_data;
    logic [2:0]    r_in_mode;

    // Window stage
    logic [DW-1:0] r_lb1 [IMG_WIDTH];
    logic [DW-1:0] r_lb2 [IMG_WIDTH];
    logic [DW-1:0] r_win [3][3];
    logic          r_s1_vld, r_s1_mask, r_s1_ten;
    logic [2:0]    r_s1_mode;

    // Gradient stage
    logic [SW-1:0]        w_pos_x, w_neg_x, w_pos_y, w_neg_y;
    logic [SW:0]          w_gsum;
    logic signed [SW-1:0] r_s2_gx, r_s2_gy;
    logic [SW-1:0]        r_s2_g;
    logic [DW-1:0]        r_s2_c;
    logic                 r_s2_vld, r_s2_mask, r_s2_ten;
    logic [2:0]           r_s2_mode;

    // Select stage
    logic [SW-1:0] w_ax, w_ay;
    logic [SW:0]   w_mag, w_res;
    logic [DW-1:0] w_sat, w_out;
    logic [DW-1:0] r_odata;
    logic          r_odval;

    // An SOF beat is pixel (0,0) and takes the live mode/enable.
    always_comb begin
        w_col  = bus.iSOF ? '0 : r_col;
        w_row  = bus.iSOF ? '0 : r_row;
        w_mode = bus.iSOF ? bus.iMODE : r_mode;
        w_ten  = bus.iSOF ? bus.iTHRESH_EN : r_ten;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_col    <= '0;
            r_row    <= '0;
            r_mode   <= '0;
            r_ten    <= 1'b0;
            r_in_vld <= 1'b0;
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_odval  <= 1'b0;
            r_odata  <= '0;
        end else begin
            r_in_vld <= bus.iDVAL;
            r_s1_vld <= r_in_vld;
            r_s2_vld <= r_s1_vld;
            r_odval  <= r_s2_vld;
            if (r_s2_vld) begin
                r_odata <= w_out;
            end
            if (bus.iDVAL) begin
                r_mode <= w_mode;
                r_ten  <= w_ten;
                if (w_col == CW'(IMG_WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (bus.iDVAL) begin
            r_in_data <= bus.iDATA;
            r_in_mask <= (w_row < 2'd2) || (w_col < CW'(2));
            r_in_mode <= w_mode;
            r_in_ten  <= w_ten;
        end
        if (r_in_vld) begin
            r_lb1[0] <= r_in_data;
            r_lb2[0] <= r_lb1[IMG_WIDTH-1];
            for (int unsigned i = 1; i < IMG_WIDTH; i++) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb2[i] <= r_lb2[i-1];
            end
            for (int unsigned r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= r_lb2[IMG_WIDTH-1];
            r_win[1][2] <= r_lb1[IMG_WIDTH-1];
            r_win[2][2] <= r_in_data;
        end
        r_s1_mask <= r_in_mask;
        r_s1_mode <= r_in_mode;
        r_s1_ten  <= r_in_ten;
        r_s2_gx   <= $signed(w_pos_x - w_neg_x);
        r_s2_gy   <= $signed(w_pos_y - w_neg_y);
        r_s2_g    <= SW'(w_gsum >> 4);
        r_s2_c    <= r_win[1][1];
        r_s2_mask <= r_s1_mask;
        r_s2_mode <= r_s1_mode;
        r_s2_ten  <= r_s1_ten;
    end

    always_comb begin
        w_pos_x = zx(r_win[0][2]) + (zx(r_win[1][2]) << 1) + zx(r_win[2][2]);
        w_neg_x = zx(r_win[0][0]) + (zx(r_win[1][0]) << 1) + zx(r_win[2][0]);
        w_pos_y = zx(r_win[2][0]) + (zx(r_win[2][1]) << 1) + zx(r_win[2][2]);
        w_neg_y = zx(r_win[0][0]) + (zx(r_win[0][1]) << 1) + zx(r_win[0][2]);
        w_gsum  = zx5(r_win[0][0]) + (zx5(r_win[0][1]) << 1) + zx5(r_win[0][2])
                + (zx5(r_win[1][0]) << 1) + (zx5(r_win[1][1]) << 2) + (zx5(r_win[1][2]) << 1)
                + zx5(r_win[2][0]) + (zx5(r_win[2][1]) << 1) + zx5(r_win[2][2]);
    end

    always_comb begin
        w_ax  = r_s2_gx[SW-1] ? $unsigned(-r_s2_gx) : $unsigned(r_s2_gx);
        w_ay  = r_s2_gy[SW-1] ? $unsigned(-r_s2_gy) : $unsigned(r_s2_gy);
        w_mag = {1'b0, w_ax} + {1'b0, w_ay};
        w_res = zx5(r_s2_c);
        case (r_s2_mode)
            3'd1:    w_res = {1'b0, w_ay};
            3'd2:    w_res = {1'b0, w_ax};
            3'd3:    w_res = w_mag;
            3'd4:    w_res = {1'b0, r_s2_g};
            default: w_res = zx5(r_s2_c);
        endcase
        w_sat = (w_res > zx5(MAXV)) ? MAXV : w_res[DW-1:0];
        // Mask wins over threshold so border garbage never reaches the output.
        if (r_s2_mask) begin
            w_out = '0;
        end else if (r_s2_ten) begin
            w_out = (w_sat >= bus.iTHRESH) ? MAXV : '0;
        end else begin
            w_out = w_sat;
        end
    end

    assign bus.oDATA = r_odata;
    assign bus.oDVAL = r_odval;
endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// Directed bench for conv3x3_stream_filter on an 8-pixel-wide image with hand-computed results.
module tb_conv3x3_stream_filter;
    localparam int unsigned DW = 12;
    localparam int          W  = 8;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [DW-1:0] out_q [$];
    int            out_cyc [$];
    int            in_cyc [$];

    always #5 clk = ~clk;

    conv3x3_stream_filter_if #(.DW(DW)) bus ();

    conv3x3_stream_filter #(
        .DW       (DW),
        .IMG_WIDTH(W),
        .CW       (CW)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.oDVAL === 1'b1) begin
            out_q.push_back(bus.oDATA);
            out_cyc.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 12'd100;
            1:       return (c >= 4) ? 12'd1000 : 12'd0;
            2:       return (c >= 4 && r >= 3) ? 12'd4095 : 12'd0;
            default: return 12'd0;
        endcase
    endfunction

    task automatic clear_capture();
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.iDVAL = 1'b0;
            bus.iSOF  = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic sof, input logic [2:0] mode,
                              input logic ten);
        @(negedge clk);
        bus.iDATA      = d;
        bus.iDVAL      = 1'b1;
        bus.iSOF       = sof;
        bus.iMODE      = mode;
        bus.iTHRESH_EN = ten;
        in_cyc.push_back(cyc + 1);
    endtask

    task automatic send_frame(input int kind, input int rows, input logic [2:0] mode0,
                              input logic [2:0] mode1, input int sw_idx, input logic ten,
                              input bit gaps, input bit sof);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(1, 0) == 1) idle(int'($urandom_range(2, 1)));
                drive_beat(pix(kind, r, c), sof && r == 0 && c == 0,
                           (r * W + c < sw_idx) ? mode0 : mode1, ten);
            end
        end
        idle(8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.oDVAL !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_odval got=%b want=0", bus.oDVAL);
        end
        n_cmp++;
        if (bus.oDATA !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_odata got=%0d want=0", bus.oDATA);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_flat();
        logic [2:0]    m;
        logic [DW-1:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            m = (pass == 0) ? 3'd3 : 3'd4;
            clear_capture();
            send_frame(0, 4, m, m, 0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (out_q.size() !== 32) begin
                n_bad++;
                $display("FAIL flat_count mode=%0d got=%0d want=32", m, out_q.size());
            end
            for (int i = 0; i < out_q.size() && i < 32; i++) begin
                want = (i / W < 2 || i % W < 2 || m == 3'd3) ? 12'd0 : 12'd100;
                n_cmp++;
                if (out_q[i] !== want) begin
                    n_bad++;
                    $display("FAIL flat_data mode=%0d idx=%0d got=%0d want=%0d", m, i, out_q[i], want);
                end
                n_cmp++;
                if (out_cyc[i] - in_cyc[i] !== 3) begin
                    n_bad++;
                    $display("FAIL flat_latency idx=%0d got=%0d want=3", i, out_cyc[i] - in_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_step();
        logic [2:0]    m;
        logic [DW-1:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            m = (pass == 0) ? 3'd2 : 3'd1;
            clear_capture();
            send_frame(1, 4, m, m, 0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (out_q.size() !== 32) begin
                n_bad++;
                $display("FAIL step_count mode=%0d got=%0d want=32", m, out_q.size());
            end
            for (int i = 0; i < out_q.size() && i < 32; i++) begin
                want = (m == 3'd2 && i / W >= 2 && (i % W == 4 || i % W == 5)) ? 12'd4000 : 12'd0;
                n_cmp++;
                if (out_q[i] !== want) begin
                    n_bad++;
                    $display("FAIL step_data mode=%0d idx=%0d got=%0d want=%0d", m, i, out_q[i], want);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int            pr [11] = '{3, 3, 4, 4, 5, 4, 5, 5, 4, 2, 1};
        int            pc [11] = '{4, 5, 4, 5, 5, 6, 6, 7, 3, 7, 5};
        logic [DW-1:0] pw [11] = '{4095, 4095, 4095, 4095, 4095, 4095, 0, 0, 0, 0, 0};
        int            k;
        clear_capture();
        send_frame(2, 6, 3'd3, 3'd3, 0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (out_q.size() !== 48) begin
            n_bad++;
            $display("FAIL sat_count got=%0d want=48", out_q.size());
        end
        for (int j = 0; j < 11; j++) begin
            k = pr[j] * W + pc[j];
            if (k < out_q.size()) begin
                n_cmp++;
                if (out_q[k] !== pw[j]) begin
                    n_bad++;
                    $display("FAIL sat_data row=%0d col=%0d got=%0d want=%0d", pr[j], pc[j],
                             out_q[k], pw[j]);
                end
            end
        end
    endtask

    task automatic test_threshold();
        int            thr [4] = '{2000, 4000, 4001, 0};
        logic [DW-1:0] v;
        logic [DW-1:0] want;
        for (int t = 0; t < 4; t++) begin
            bus.iTHRESH = 12'(thr[t]);
            clear_capture();
            send_frame(1, 4, 3'd2, 3'd2, 0, 1'b1, 1'b0, 1'b1);
            n_cmp++;
            if (out_q.size() !== 32) begin
                n_bad++;
                $display("FAIL thr_count thr=%0d got=%0d want=32", thr[t], out_q.size());
            end
            for (int i = 0; i < out_q.size() && i < 32; i++) begin
                v    = (i % W == 4 || i % W == 5) ? 12'd4000 : 12'd0;
                want = (i / W < 2 || i % W < 2) ? 12'd0 : ((int'(v) >= thr[t]) ? 12'd4095 : 12'd0);
                n_cmp++;
                if (out_q[i] !== want) begin
                    n_bad++;
                    $display("FAIL thr_data thr=%0d idx=%0d got=%0d want=%0d", thr[t], i,
                             out_q[i], want);
                end
            end
        end
        bus.iTHRESH = 12'd0;
    endtask

    task automatic test_gaps();
        logic [DW-1:0] ref_q [$];
        clear_capture();
        send_frame(1, 4, 3'd2, 3'd2, 0, 1'b0, 1'b0, 1'b1);
        ref_q = out_q;
        clear_capture();
        send_frame(1, 4, 3'd2, 3'd2, 0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (out_q.size() !== ref_q.size()) begin
            n_bad++;
            $display("FAIL gap_count got=%0d want=%0d", out_q.size(), ref_q.size());
        end
        for (int i = 0; i < out_q.size() && i < ref_q.size(); i++) begin
            n_cmp++;
            if (out_q[i] !== ref_q[i]) begin
                n_bad++;
                $display("FAIL gap_data idx=%0d got=%0d want=%0d", i, out_q[i], ref_q[i]);
            end
            n_cmp++;
            if (out_cyc[i] - in_cyc[i] !== 3) begin
                n_bad++;
                $display("FAIL gap_latency idx=%0d got=%0d want=3", i, out_cyc[i] - in_cyc[i]);
            end
        end
    endtask

    task automatic test_mode_change();
        logic [DW-1:0] want;
        clear_capture();
        send_frame(1, 4, 3'd2, 3'd1, 10, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (out_q.size() !== 32) begin
            n_bad++;
            $display("FAIL modechg_count got=%0d want=32", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < 32; i++) begin
            want = (i / W >= 2 && (i % W == 4 || i % W == 5)) ? 12'd4000 : 12'd0;
            n_cmp++;
            if (out_q[i] !== want) begin
                n_bad++;
                $display("FAIL modechg_data idx=%0d got=%0d want=%0d", i, out_q[i], want);
            end
        end
        clear_capture();
        send_frame(1, 4, 3'd1, 3'd1, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < out_q.size() && i < 32; i++) begin
            n_cmp++;
            if (out_q[i] !== 12'd0) begin
                n_bad++;
                $display("FAIL modechg_next idx=%0d got=%0d want=0", i, out_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] want;
        clear_capture();
        for (int i = 0; i < 12; i++) drive_beat(12'd100, i == 0, 3'd4, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        bus.iDVAL = 1'b0;
        bus.iSOF  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.oDVAL !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_odval got=%b want=0", bus.oDVAL);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        n_cmp++;
        if (out_q.size() !== 9) begin
            n_bad++;
            $display("FAIL rstmid_inflight got=%0d want=9", out_q.size());
        end
        // No SOF after reset: latched mode is back to passthrough despite iMODE=3 on the bus.
        clear_capture();
        send_frame(0, 3, 3'd3, 3'd3, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (out_q.size() !== 24) begin
            n_bad++;
            $display("FAIL rstmid_count got=%0d want=24", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < 24; i++) begin
            want = (i / W < 2 || i % W < 2) ? 12'd0 : 12'd100;
            n_cmp++;
            if (out_q[i] !== want) begin
                n_bad++;
                $display("FAIL rstmid_data idx=%0d got=%0d want=%0d", i, out_q[i], want);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.iDATA      = '0;
        bus.iDVAL      = 1'b0;
        bus.iSOF       = 1'b0;
        bus.iMODE      = 3'd0;
        bus.iTHRESH    = '0;
        bus.iTHRESH_EN = 1'b0;
        test_reset();
        test_flat();
        test_step();
        test_saturation();
        test_threshold();
        test_gaps();
        test_mode_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
